// File: rtl/seq_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_pkg
//  Description : Shared types and the flag-derivation helper for the
//                digit-serial magnitude comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_cmp_pkg;

    // Controller states; the top mirrors these as fixed-width constants.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // All eight relation flags, MSB first in the order they are listed.
    typedef struct packed {
        logic gtu;
        logic gts;
        logic ltu;
        logic lts;
        logic geu;
        logic ges;
        logic leu;
        logic les;
    } cmp_flags_t;

    // Turns the final unsigned lt/gt and the operand signs into all flags.
    // With differing signs the signed order is the reverse of the unsigned
    // one, so the signed pair is the unsigned pair XOR the sign mismatch.
    function automatic cmp_flags_t flags_from(input logic lt, input logic gt,
                                              input logic sign_a, input logic sign_b);
        cmp_flags_t f;
        logic       x;
        x     = sign_a ^ sign_b;
        f.gtu = gt;
        f.ltu = lt;
        f.geu = ~lt;
        f.leu = ~gt;
        f.gts = gt ^ x;
        f.lts = lt ^ x;
        f.ges = ~(lt ^ x);
        f.les = ~(gt ^ x);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmp_lcu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_lcu_if
//  Description : Operand and result handshake bundle of the comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_cmp_lcu_if #(
    parameter int WIDTH = 14
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gtu, gts, ltu, lts, geu, ges, leu, les;

    // Producer/consumer side driving operands and taking results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gtu, gts, ltu, lts, geu, ges, leu, les
    );

    // Comparator side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gtu, gts, ltu, lts, geu, ges, leu, les
    );
endinterface
`default_nettype wire

// File: rtl/cmp_digit_step.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_digit_step
//  Description : One stage of the LSB-first borrow-style compare chain.
//                A differing digit overrides everything below it; an equal
//                digit passes the lower-order verdict through.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_digit_step #(
    parameter int DIGIT = 2
) (
    input  wire logic [DIGIT-1:0] da,
    input  wire logic [DIGIT-1:0] db,
    input  wire logic             lt_in,
    input  wire logic             gt_in,
    output logic                  lt_out,
    output logic                  gt_out
);

    // Higher-order digit decides when it differs, else keep running verdict.
    always_comb begin
        lt_out = lt_in;
        gt_out = gt_in;
        if (da != db) begin
            lt_out = (da < db);
            gt_out = (da > db);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_cmp_lcu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_cmp_lcu
//  Description : Digit-serial magnitude comparator. Accepts two operands,
//                walks them LSB-first DIGIT bits per cycle and returns the
//                eight unsigned/signed relation flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_cmp_lcu
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int DIGIT = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seq_cmp_lcu_if.slave  bus
);

    localparam int              N      = WIDTH / DIGIT;
    localparam int              CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   c_LAST = CW'(N - 1);
    localparam logic [1:0]      c_IDLE = IDLE;
    localparam logic [1:0]      c_BUSY = BUSY;
    localparam logic [1:0]      c_DONE = DONE;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("seq_cmp_lcu: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_lt;
    logic             r_gt;
    cmp_flags_t       r_flags;
    logic             w_lt;
    logic             w_gt;

    cmp_digit_step #(.DIGIT(DIGIT)) u_step (
        .da     (r_sa[DIGIT-1:0]),
        .db     (r_sb[DIGIT-1:0]),
        .lt_in  (r_lt),
        .gt_in  (r_gt),
        .lt_out (w_lt),
        .gt_out (w_gt)
    );

    // Controller, digit walk and result capture; flags change only on BUSY->DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_sa     <= bus.a;
                        r_sb     <= bus.b;
                        r_sign_a <= bus.a[WIDTH-1];
                        r_sign_b <= bus.b[WIDTH-1];
                        r_lt     <= 1'b0;
                        r_gt     <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_lt  <= w_lt;
                    r_gt  <= w_gt;
                    r_sa  <= r_sa >> DIGIT;
                    r_sb  <= r_sb >> DIGIT;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_flags <= flags_from(w_lt, w_gt, r_sign_a, r_sign_b);
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Handshake status is a pure decode of the state (in_ready also masked by rst).
    always_comb begin
        bus.in_ready  = (r_state == c_IDLE) && !rst;
        bus.out_valid = (r_state == c_DONE);
        bus.gtu       = r_flags.gtu;
        bus.gts       = r_flags.gts;
        bus.ltu       = r_flags.ltu;
        bus.lts       = r_flags.lts;
        bus.geu       = r_flags.geu;
        bus.ges       = r_flags.ges;
        bus.leu       = r_flags.leu;
        bus.les       = r_flags.les;
    end

endmodule
`default_nettype wire
